// File: rtl/mem_bus_controller_pkg.sv
// Shared definitions for the CPU-to-SRAM/UART bus controller:
// access-type encoding, UART register addresses, FSM states and
// address-decode classes.
package mem_bus_controller_pkg;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int RAM_ADDR_W = 18;

    localparam logic [1:0] MC_NONE  = 2'b00;
    localparam logic [1:0] MC_LOAD  = 2'b01;
    localparam logic [1:0] MC_STORE = 2'b10;

    localparam logic [ADDR_W-1:0] UART_DATA_ADDR = 16'hBF00;
    localparam logic [ADDR_W-1:0] UART_STAT_ADDR = 16'hBF01;

    typedef enum logic [2:0] {
        IDLE,
        A_SETUP,
        A_LATCH,
        A_WE,
        A_HOLD,
        B_SETUP,
        B_LATCH,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SEL_SRAM,
        SEL_UART_DATA,
        SEL_UART_STAT
    } sel_t;

    // The reserved code 11 behaves exactly like "no access".
    function automatic logic [1:0] norm_op(input logic [1:0] mc);
        return ((mc == MC_LOAD) || (mc == MC_STORE)) ? mc : MC_NONE;
    endfunction

endpackage

// File: rtl/mem_bus_controller_addr_decoder.sv
// Combinational classification of a data-port address into
// SRAM, UART data register or UART status register.
module mem_addr_decoder
    import mem_bus_controller_pkg::*;
(
    input  logic [ADDR_W-1:0] i_addr,
    output sel_t              o_sel
);

    // Two fixed UART register addresses; everything else is SRAM.
    always_comb begin
        o_sel = SEL_SRAM;
        if (i_addr == UART_DATA_ADDR) begin
            o_sel = SEL_UART_DATA;
        end else if (i_addr == UART_STAT_ADDR) begin
            o_sel = SEL_UART_STAT;
        end
    end

endmodule

// File: rtl/mem_bus_controller.sv
// Serialises one optional CPU data access (A) followed by one instruction
// fetch (B) per CPU cycle onto a single asynchronous SRAM bus shared with
// a UART. All bus strobes and results are registered; stall stays high
// until the DONE cycle.
module mem_bus_controller
    import mem_bus_controller_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     Aaddr,
    input  logic [DATA_W-1:0]     dataWrite,
    input  logic [1:0]            memControl,
    input  logic [ADDR_W-1:0]     Baddr,
    output logic [DATA_W-1:0]     AmemRead,
    output logic [DATA_W-1:0]     BmemRead,
    output logic                  stall,
    output logic [RAM_ADDR_W-1:0] ramAddr,
    output logic [DATA_W-1:0]     ramDataOut,
    output logic                  ramDataOe,
    input  logic [DATA_W-1:0]     ramDataIn,
    output logic                  ramEn_n,
    output logic                  ramOe_n,
    output logic                  ramWe_n,
    output logic                  uartRdn,
    output logic                  uartWrn,
    input  logic                  dataReady,
    input  logic                  tbre,
    input  logic                  tsre
);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_Aaddr;
    logic [ADDR_W-1:0]   r_Baddr;
    logic [DATA_W-1:0]   r_dataWrite;
    logic [1:0]          r_op;

    logic [ADDR_W-1:0]   w_Aaddr;
    logic [ADDR_W-1:0]   w_Baddr;
    logic [DATA_W-1:0]   w_dataWrite;
    logic [1:0]          w_op;
    sel_t                w_sel;

    // Outputs are registered for the state being entered, so on the IDLE
    // exit edge the live CPU inputs are used; afterwards the captured copies.
    assign w_Aaddr     = (r_state == IDLE) ? Aaddr : r_Aaddr;
    assign w_Baddr     = (r_state == IDLE) ? Baddr : r_Baddr;
    assign w_dataWrite = (r_state == IDLE) ? dataWrite : r_dataWrite;
    assign w_op        = (r_state == IDLE) ? norm_op(memControl) : r_op;

    mem_addr_decoder u_dec (
        .i_addr (w_Aaddr),
        .o_sel  (w_sel)
    );

    // Capture the CPU request once per transaction so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (r_state == IDLE) begin
            r_Aaddr     <= Aaddr;
            r_Baddr     <= Baddr;
            r_dataWrite <= dataWrite;
            r_op        <= norm_op(memControl);
        end
    end

    // Sequence: optional A phase (load or store), then the B fetch, then DONE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_op == MC_NONE) ? B_SETUP : A_SETUP;
            A_SETUP: w_next = (w_op == MC_LOAD) ? A_LATCH : A_WE;
            A_LATCH: w_next = B_SETUP;
            A_WE:    w_next = A_HOLD;
            A_HOLD:  w_next = B_SETUP;
            B_SETUP: w_next = B_LATCH;
            B_LATCH: w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register plus registered bus strobes and read results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            ramEn_n    <= 1'b1;
            ramOe_n    <= 1'b1;
            ramWe_n    <= 1'b1;
            uartRdn    <= 1'b1;
            uartWrn    <= 1'b1;
            ramDataOe  <= 1'b0;
            ramAddr    <= '0;
            ramDataOut <= '0;
            AmemRead   <= '0;
            BmemRead   <= '0;
            stall      <= 1'b1;
        end else begin
            r_state   <= w_next;
            ramEn_n   <= 1'b1;
            ramOe_n   <= 1'b1;
            ramWe_n   <= 1'b1;
            uartRdn   <= 1'b1;
            uartWrn   <= 1'b1;
            ramDataOe <= 1'b0;
            stall     <= 1'b1;

            // Read data is sampled on the edge that leaves the latch state.
            if (r_state == A_LATCH) begin
                case (w_sel)
                    SEL_UART_DATA: AmemRead <= {8'h00, ramDataIn[7:0]};
                    SEL_UART_STAT: AmemRead <= {14'b0, dataReady, tbre & tsre};
                    default:       AmemRead <= ramDataIn;
                endcase
            end
            if (r_state == B_LATCH) begin
                BmemRead <= ramDataIn;
            end

            case (w_next)
                A_SETUP, A_LATCH, A_WE, A_HOLD: begin
                    ramAddr <= {2'b00, w_Aaddr};
                    if (w_op == MC_STORE) begin
                        ramDataOut <= w_dataWrite;
                        // The status register is read-only: no bus activity at all.
                        if (w_sel != SEL_UART_STAT) begin
                            ramDataOe <= 1'b1;
                        end
                        if (w_sel == SEL_SRAM) begin
                            ramEn_n <= 1'b0;
                            if (w_next == A_WE) begin
                                ramWe_n <= 1'b0;
                            end
                        end else if ((w_sel == SEL_UART_DATA) && (w_next == A_WE)) begin
                            uartWrn <= 1'b0;
                        end
                    end else begin
                        if (w_sel == SEL_SRAM) begin
                            ramEn_n <= 1'b0;
                            ramOe_n <= 1'b0;
                        end else if (w_sel == SEL_UART_DATA) begin
                            uartRdn <= 1'b0;
                        end
                    end
                end
                B_SETUP, B_LATCH: begin
                    ramAddr <= {2'b00, w_Baddr};
                    ramEn_n <= 1'b0;
                    ramOe_n <= 1'b0;
                end
                DONE: begin
                    stall <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_controller.sv
// Scoreboard bench for mem_bus_controller: a behavioural SRAM/UART
// environment, a transaction-level reference model that predicts results
// and per-transaction strobe counts, and a monitor that checks at DONE.
module tb_mem_bus_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Aaddr, dataWrite, Baddr;
    logic [1:0]  memControl;
    logic [15:0] AmemRead, BmemRead;
    logic        stall;
    logic [17:0] ramAddr;
    logic [15:0] ramDataOut, ramDataIn;
    logic        ramDataOe, ramEn_n, ramOe_n, ramWe_n, uartRdn, uartWrn;
    logic        dataReady, tbre, tsre;
    logic [7:0]  uart_rx;

    logic [15:0] env_mem   [0:65535];
    logic [15:0] model_mem [0:65535];
    logic [15:0] last_a;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] wdata;
        int cyc;
        int en;
        int oe;
        int we;
        int wrn;
        int rdn;
        int doe;
    } exp_t;

    exp_t sb_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_bus_controller dut (
        .clk        (clk),
        .rst        (rst),
        .Aaddr      (Aaddr),
        .dataWrite  (dataWrite),
        .memControl (memControl),
        .Baddr      (Baddr),
        .AmemRead   (AmemRead),
        .BmemRead   (BmemRead),
        .stall      (stall),
        .ramAddr    (ramAddr),
        .ramDataOut (ramDataOut),
        .ramDataOe  (ramDataOe),
        .ramDataIn  (ramDataIn),
        .ramEn_n    (ramEn_n),
        .ramOe_n    (ramOe_n),
        .ramWe_n    (ramWe_n),
        .uartRdn    (uartRdn),
        .uartWrn    (uartWrn),
        .dataReady  (dataReady),
        .tbre       (tbre),
        .tsre       (tsre)
    );

    // External bus: SRAM drives when selected and output-enabled, UART when read-strobed.
    assign ramDataIn = (!ramEn_n && !ramOe_n) ? env_mem[ramAddr[15:0]] :
                       (!uartRdn ? {8'hC3, uart_rx} : 16'hFFFF);

    always @(posedge clk) begin
        if (!ramEn_n && !ramWe_n) env_mem[ramAddr[15:0]] <= ramDataOut;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: accumulate strobe activity per transaction, compare at DONE.
    initial begin
        int m_cyc, m_en, m_oe, m_we, m_wrn, m_rdn, m_doe, m_bad;
        logic [15:0] m_wdata;
        exp_t e;
        m_cyc = 0; m_en = 0; m_oe = 0; m_we = 0; m_wrn = 0; m_rdn = 0; m_doe = 0; m_bad = 0;
        m_wdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_cyc = 0; m_en = 0; m_oe = 0; m_we = 0; m_wrn = 0; m_rdn = 0; m_doe = 0; m_bad = 0;
            end else begin
                m_cyc++;
                if (!ramEn_n) m_en++;
                if (!ramOe_n) m_oe++;
                if (!ramWe_n) m_we++;
                if (!uartRdn) m_rdn++;
                if (ramDataOe) m_doe++;
                if (!uartWrn) begin
                    m_wrn++;
                    m_wdata = ramDataOut;
                end
                if (ramDataOe && !ramOe_n) m_bad++;
                if ((!uartWrn || !uartRdn) && !ramEn_n) m_bad++;
                if (ramAddr[17:16] != 2'b00) m_bad++;
                if (!stall) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("AmemRead", AmemRead, e.a);
                        check("BmemRead", BmemRead, e.b);
                        check("cycles", m_cyc, e.cyc);
                        check("ramEn_low", m_en, e.en);
                        check("ramOe_low", m_oe, e.oe);
                        check("ramWe_low", m_we, e.we);
                        check("uartWrn_low", m_wrn, e.wrn);
                        check("uartRdn_low", m_rdn, e.rdn);
                        check("ramDataOe_high", m_doe, e.doe);
                        check("bus_conflicts", m_bad, 0);
                        if (e.wrn != 0) check("uart_wdata", m_wdata, e.wdata);
                    end
                    m_cyc = 0; m_en = 0; m_oe = 0; m_we = 0; m_wrn = 0; m_rdn = 0; m_doe = 0; m_bad = 0;
                end
            end
        end
    end

    // Reference model: predicts one whole CPU cycle from the access rules.
    task automatic issue(input logic [1:0] mc, input logic [15:0] aa, input logic [15:0] wd,
                         input logic [15:0] ba, input logic dr, input logic tb, input logic ts,
                         input logic [7:0] rx);
        exp_t e;
        e.cyc = 4; e.en = 2; e.oe = 2; e.we = 0; e.wrn = 0; e.rdn = 0; e.doe = 0;
        e.wdata = wd;
        if (mc == 2'b01) begin
            e.cyc = 6;
            if (aa == 16'hBF00) begin
                last_a = {8'h00, rx};
                e.rdn  = 2;
            end else if (aa == 16'hBF01) begin
                last_a = {14'b0, dr, tb & ts};
            end else begin
                last_a = model_mem[aa];
                e.en = 4;
                e.oe = 4;
            end
        end else if (mc == 2'b10) begin
            e.cyc = 7;
            if (aa == 16'hBF00) begin
                e.wrn = 1;
                e.doe = 3;
            end else if (aa != 16'hBF01) begin
                model_mem[aa] = wd;
                e.en  = 5;
                e.we  = 1;
                e.doe = 3;
            end
        end
        e.a = last_a;
        e.b = model_mem[ba];
        sb_q.push_back(e);
        memControl = mc; Aaddr = aa; dataWrite = wd; Baddr = ba;
        dataReady = dr; tbre = tb; tsre = ts; uart_rx = rx;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!stall) return;
        end
        n_fail++;
        $display("FAIL done_timeout: stall never dropped, got 1 expected 0");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    endtask

    task automatic run(input logic [1:0] mc, input logic [15:0] aa, input logic [15:0] wd,
                       input logic [15:0] ba, input logic dr, input logic tb, input logic ts,
                       input logic [7:0] rx, input int edges);
        issue(mc, aa, wd, ba, dr, tb, ts, rx);
        repeat (edges) @(posedge clk);
        #1;
        memControl = 2'($urandom_range(0, 3));
        Aaddr      = 16'($urandom);
        dataWrite  = 16'($urandom);
        Baddr      = 16'($urandom);
        wait_done();
    endtask

    task automatic run_random(input int edges);
        logic [15:0] aa, ba;
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0)      aa = 16'hBF00;
        else if (sel == 1) aa = 16'hBF01;
        else if (sel < 6)  aa = {12'h800, 4'($urandom)};
        else               aa = 16'($urandom);
        ba = ($urandom_range(0, 1) == 1) ? {12'h800, 4'($urandom)} : 16'($urandom);
        run(2'($urandom_range(0, 3)), aa, 16'($urandom), ba, 1'($urandom), 1'($urandom),
            1'($urandom), 8'($urandom), edges);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stall"}, stall, 1);
        check({tag, "_ramEn_n"}, ramEn_n, 1);
        check({tag, "_ramOe_n"}, ramOe_n, 1);
        check({tag, "_ramWe_n"}, ramWe_n, 1);
        check({tag, "_uartRdn"}, uartRdn, 1);
        check({tag, "_uartWrn"}, uartWrn, 1);
        check({tag, "_ramDataOe"}, ramDataOe, 0);
        check({tag, "_ramAddr"}, ramAddr, 0);
        check({tag, "_ramDataOut"}, ramDataOut, 0);
        check({tag, "_AmemRead"}, AmemRead, 0);
        check({tag, "_BmemRead"}, BmemRead, 0);
    endtask

    initial begin
        bit found;
        logic [15:0] abort_wd;
        for (int i = 0; i < 65536; i++) begin
            env_mem[i]   = 16'(i * 7) ^ 16'hA55A;
            model_mem[i] = 16'(i * 7) ^ 16'hA55A;
        end
        env_mem[4]   = 16'h1234;
        model_mem[4] = 16'h1234;
        last_a = '0;
        rst = 1'b1;
        memControl = 2'b00; Aaddr = '0; dataWrite = '0; Baddr = '0;
        dataReady = 1'b0; tbre = 1'b0; tsre = 1'b0; uart_rx = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");

        @(posedge clk);
        #2;
        rst = 1'b0;
        run(2'b00, 16'h0000, 16'h0000, 16'h0004, 1'b0, 1'b0, 1'b0, 8'h00, 1);
        run(2'b10, 16'h8000, 16'hBEEF, 16'h0004, 1'b0, 1'b0, 1'b0, 8'h00, 2);
        run(2'b01, 16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b0, 8'h00, 2);
        run(2'b01, 16'hBF01, 16'h0000, 16'h0010, 1'b1, 1'b1, 1'b0, 8'h00, 2);
        run(2'b10, 16'hBF00, 16'h0041, 16'h0011, 1'b0, 1'b0, 1'b0, 8'h00, 2);
        run(2'b11, 16'h8000, 16'h7777, 16'h8001, 1'b0, 1'b0, 1'b0, 8'h00, 2);
        run(2'b01, 16'hBF00, 16'h0000, 16'h0012, 1'b0, 1'b0, 1'b0, 8'h5A, 2);
        run(2'b10, 16'hBF01, 16'h1111, 16'h0013, 1'b1, 1'b1, 1'b1, 8'h00, 2);
        for (int i = 0; i < 150; i++) run_random(2);

        // Reset in the middle of a store, during the write strobe.
        abort_wd = 16'($urandom);
        memControl = 2'b10; Aaddr = 16'h8003; dataWrite = abort_wd; Baddr = 16'h0020;
        repeat (2) @(posedge clk);
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            if (!ramWe_n) found = 1'b1;
        end
        check("abort_reached_we", found, 1);
        if (found) model_mem[16'h8003] = abort_wd;
        rst = 1'b1;
        last_a = '0;
        @(negedge clk);
        check_reset_outputs("abort");
        @(posedge clk);
        #2;
        rst = 1'b0;
        run(2'b01, 16'h8003, 16'h0000, 16'h8003, 1'b0, 1'b0, 1'b0, 8'h00, 1);
        for (int i = 0; i < 60; i++) run_random(2);

        @(negedge clk);
        check("queue_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

endmodule
